// File: rtl/cube_pkg.sv
// Shared types and constants for the player-cube controller: FSM states,
// motion-profile band edges and the time_gap saturation limit.
package cube_pkg;

    typedef enum logic [1:0] {
        STAND = 2'd0,
        RISE  = 2'd1,
        FALL  = 2'd2,
        DEAD  = 2'd3
    } cube_state_t;

    localparam int BAND_1   = 80;
    localparam int BAND_2   = 160;
    localparam int BAND_3   = 240;
    localparam int RISE_END = 320;
    localparam int TG_MAX   = 511;

endpackage

// File: rtl/cube_ctrl_if.sv
// Bundle of button inputs, floor descriptions and cube outputs exchanged
// between the cube controller and its surroundings.
interface cube_ctrl_if;

    logic       jump;
    logic       move_l;
    logic       move_r;
    logic [9:0] floor_pos_x0;
    logic [9:0] floor_pos_x1;
    logic [9:0] floor_pos_x2;
    logic [9:0] floor_pos_x3;
    logic [9:0] floor_pos_y0;
    logic [9:0] floor_pos_y1;
    logic [9:0] floor_pos_y2;
    logic [9:0] floor_pos_y3;
    logic [3:0] enable;
    logic [9:0] cube_x;
    logic [9:0] cube_y;
    logic       hit_ceiling;
    logic [8:0] time_gap;
    logic       game_over;

    modport master (
        output jump, move_l, move_r,
        output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
        output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
        output enable,
        input  cube_x, cube_y, hit_ceiling, time_gap, game_over
    );

    modport slave (
        input  jump, move_l, move_r,
        input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
        input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
        input  enable,
        output cube_x, cube_y, hit_ceiling, time_gap, game_over
    );

endinterface

// File: rtl/cube_step_profile.sv
// Decides whether the cube moves one pixel this cycle, given the motion
// phase counter: rising slows down over time, falling speeds up.
module cube_step_profile
    import cube_pkg::*;
(
    input  logic [8:0] tg,
    input  logic       rise,
    output logic       step
);

    always_comb begin
        step = 1'b0;
        if (tg != 9'd0) begin
            if (rise) begin
                if (tg < 9'(BAND_1))
                    step = 1'b1;
                else if (tg < 9'(BAND_2))
                    step = ~tg[0];
                else if (tg < 9'(BAND_3))
                    step = (tg[1:0] == 2'b00);
                else if (tg < 9'(RISE_END))
                    step = (tg[2:0] == 3'b000);
            end else begin
                if (tg < 9'(BAND_1))
                    step = (tg[2:0] == 3'b000);
                else if (tg < 9'(BAND_2))
                    step = (tg[1:0] == 2'b00);
                else if (tg < 9'(BAND_3))
                    step = ~tg[0];
                else
                    step = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cube_ctrl.sv
// Player-cube controller: jump/gravity motion, horizontal buttons, landing
// on four platforms and ceiling contact. Optional macro DOUBLE_JUMP_EN.
module cube_ctrl
    import cube_pkg::*;
#(
    parameter int CUBE_W   = 20,
    parameter int CUBE_H   = 20,
    parameter int FLOOR_W  = 100,
    parameter int CEIL_Y   = 40,
    parameter int BOTTOM_Y = 480,
    parameter int SCREEN_W = 640,
    parameter int START_X  = 160,
    parameter int START_Y  = 310
)
(
    input logic        clk,
    input logic        rst,
    cube_ctrl_if.slave bus
);

    cube_state_t state_q, state_d;
    logic [9:0]  cube_x_q, cube_x_d;
    logic [9:0]  cube_y_q, cube_y_d;
    logic [8:0]  time_gap_q, time_gap_d;
    logic [8:0]  time_gap_inc;
    logic        hit_ceiling_q, hit_ceiling_d;
    logic        game_over_q;
    logic        jump_q;
    logic        jump_edge;
    logic        double_jump_go;
    logic        supported;
    logic        step;
    logic        rise_phase;
    logic [9:0]  floor_x [4];
    logic [9:0]  floor_y [4];

    assign floor_x[0] = bus.floor_pos_x0;
    assign floor_x[1] = bus.floor_pos_x1;
    assign floor_x[2] = bus.floor_pos_x2;
    assign floor_x[3] = bus.floor_pos_x3;
    assign floor_y[0] = bus.floor_pos_y0;
    assign floor_y[1] = bus.floor_pos_y1;
    assign floor_y[2] = bus.floor_pos_y2;
    assign floor_y[3] = bus.floor_pos_y3;

    assign jump_edge    = bus.jump & ~jump_q;
    assign rise_phase   = (state_q == RISE);
    assign time_gap_inc = (time_gap_q == 9'(TG_MAX)) ? time_gap_q : time_gap_q + 9'd1;

    cube_step_profile u_profile (
        .tg   (time_gap_q),
        .rise (rise_phase),
        .step (step)
    );

    // 11-bit sums so a platform near the bottom/right edge cannot alias via wrap.
    always_comb begin
        supported = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.enable[i]
                && ({1'b0, cube_y_q} + 11'(CUBE_H) == {1'b0, floor_y[i]})
                && ({1'b0, cube_x_q} + 11'(CUBE_W) >  {1'b0, floor_x[i]})
                && ({1'b0, cube_x_q} < {1'b0, floor_x[i]} + 11'(FLOOR_W)))
                supported = 1'b1;
        end
    end

`ifdef DOUBLE_JUMP_EN
    logic credit_q, credit_d;

    assign double_jump_go = jump_edge & credit_q;

    // One mid-air jump per flight; landing hands the credit back.
    always_comb begin
        credit_d = credit_q;
        if (state_q == FALL && state_d == RISE)
            credit_d = 1'b0;
        else if (state_q != STAND && state_d == STAND)
            credit_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            credit_q <= 1'b1;
        else
            credit_q <= credit_d;
    end
`else
    assign double_jump_go = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cube_x_d      = cube_x_q;
        cube_y_d      = cube_y_q;
        time_gap_d    = time_gap_q;
        hit_ceiling_d = hit_ceiling_q;

        case (state_q)
            STAND: begin
                time_gap_d    = 9'd0;
                hit_ceiling_d = 1'b0;
                if (jump_edge) begin
                    state_d    = RISE;
                    time_gap_d = 9'd1;
                end else if (!supported) begin
                    state_d    = FALL;
                    time_gap_d = 9'd1;
                end
            end
            RISE: begin
                if (time_gap_q == 9'(RISE_END)) begin
                    state_d       = FALL;
                    time_gap_d    = 9'd1;
                    hit_ceiling_d = 1'b0;
                end else begin
                    time_gap_d = time_gap_q + 9'd1;
                    if (step) begin
                        if (cube_y_q > 10'(CEIL_Y))
                            cube_y_d = cube_y_q - 10'd1;
                        else
                            hit_ceiling_d = 1'b1;
                    end
                end
            end
            FALL: begin
                time_gap_d = time_gap_inc;
                if (cube_y_q >= 10'(BOTTOM_Y)) begin
                    state_d = DEAD;
                end else if (double_jump_go) begin
                    state_d    = RISE;
                    time_gap_d = 9'd1;
                end else if (step) begin
                    if (supported) begin
                        state_d    = STAND;
                        time_gap_d = 9'd0;
                    end else begin
                        cube_y_d = cube_y_q + 10'd1;
                    end
                end
            end
            DEAD: begin
                hit_ceiling_d = 1'b0;
            end
            default: begin
                state_d = STAND;
            end
        endcase

        if (state_q != DEAD) begin
            if (bus.move_l && !bus.move_r && cube_x_q != 10'd0)
                cube_x_d = cube_x_q - 10'd1;
            else if (bus.move_r && !bus.move_l && cube_x_q < 10'(SCREEN_W - CUBE_W))
                cube_x_d = cube_x_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= STAND;
            cube_x_q      <= 10'(START_X);
            cube_y_q      <= 10'(START_Y);
            time_gap_q    <= 9'd0;
            hit_ceiling_q <= 1'b0;
            game_over_q   <= 1'b0;
            jump_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cube_x_q      <= cube_x_d;
            cube_y_q      <= cube_y_d;
            time_gap_q    <= time_gap_d;
            hit_ceiling_q <= hit_ceiling_d;
            game_over_q   <= (state_d == DEAD);
            jump_q        <= bus.jump;
        end
    end

    assign bus.cube_x      = cube_x_q;
    assign bus.cube_y      = cube_y_q;
    assign bus.time_gap    = time_gap_q;
    assign bus.hit_ceiling = hit_ceiling_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: doc/cube_ctrl.md
Name: cube_ctrl

Overview:
- Player-cube controller; the counterpart of the floor generator.
- Moves the cube vertically (jump rise / gravity fall) and horizontally (left/right buttons), and detects landing on the four floor platforms and contact with the ceiling.
- Drives the hit_ceiling and time_gap signals that the floor generator consumes to scroll the floors down.
- Sits between the button debouncers and the floor generator / VGA renderer.

Parameters:
- CUBE_W, 20, cube width in pixels
- CUBE_H, 20, cube height in pixels
- FLOOR_W, 100, platform width; floor_pos_x is the platform's left edge
- CEIL_Y, 40, cube_y value at which the cube touches the ceiling
- BOTTOM_Y, 480, cube_y at or beyond which the game is over
- SCREEN_W, 640, horizontal screen extent
- START_X, 160, reset value of cube_x
- START_Y, 310, reset value of cube_y (cube resting on floor 0 at its reset y of 330)

Ports:
- clk  in  1  system/frame clock
- rst  in  1  asynchronous, active-low reset
- jump  in  1  level; one jump per rising edge, internally edge-detected
- move_l  in  1  level; move left
- move_r  in  1  level; move right
- floor_pos_x0..x3  in  10 each  platform left edges
- floor_pos_y0..y3  in  10 each  platform top edges
- enable  in  4  platform valid bits
- cube_x  out  10  cube left edge
- cube_y  out  10  cube top edge
- hit_ceiling  out  1  cube pinned at ceiling while rising
- time_gap  out  9  motion phase counter
- game_over  out  1  cube fell off screen

Behaviour:
Reset values (async, rst low):
- state=STAND, cube_x=START_X, cube_y=START_Y
- time_gap=0, hit_ceiling=0, game_over=0, jump edge register=0

State machine:
- States: STAND, RISE, FALL, DEAD. All outputs are registered.

Step profile, evaluated on the current time_gap, value tg:
- RISE step:
  - tg in 1..79: every cycle
  - tg in 80..159: when tg[0]==0
  - tg in 160..239: when tg[1:0]==0
  - tg in 240..319: when tg[2:0]==0
  - otherwise: no step
- FALL step:
  - tg in 1..79: when tg[2:0]==0
  - tg in 80..159: when tg[1:0]==0
  - tg in 160..239: when tg[0]==0
  - tg >= 240: every cycle
- tg==0: never a step.

Support test:
- Floor i supports the cube when all of the following hold:
  - enable[i]
  - cube_y+CUBE_H == floor_pos_yi
  - cube_x+CUBE_W > floor_pos_xi
  - cube_x < floor_pos_xi+FLOOR_W
- All sums are computed at 11 bits, with no wrap.
- "supported" is the OR over the four floors.

STAND:
- time_gap=0.
- Jump edge -> RISE, time_gap<=1.
- Else if not supported -> FALL, time_gap<=1.

RISE:
- time_gap increments by 1 each cycle.
- On a rise step:
  - cube_y > CEIL_Y: cube_y decrements by 1.
  - cube_y == CEIL_Y: cube_y holds and hit_ceiling<=1 (sticky for the rest of RISE).
- At time_gap==320: next state FALL, time_gap<=1, hit_ceiling<=0.

FALL:
- time_gap increments, saturating at 511.
- On a fall step:
  - supported: go to STAND, cube_y unchanged, time_gap<=0.
  - otherwise: cube_y increments by 1.
- cube_y >= BOTTOM_Y -> DEAD.
- Jump is ignored (see optional feature).

DEAD:
- game_over=1.
- All motion frozen; hit_ceiling=0.
- Left only by reset.

Horizontal motion (all states except DEAD):
- move_l only: cube_x-1, clamped at 0.
- move_r only: cube_x+1, clamped at SCREEN_W-CUBE_W.
- Both or neither pressed: hold.

Same-cycle events:
- Horizontal and vertical updates occur in the same cycle.
- The support test always uses the current registered cube_x/cube_y.

Optional Feature:
DOUBLE_JUMP_EN:
- Defined:
  - One extra jump is allowed while in FALL: a jump edge forces RISE with time_gap<=1 and consumes the credit.
  - The credit is restored on entering STAND and on reset.
- Undefined:
  - Jump in FALL is ignored; no credit register exists.

Decomposition:
- Package cube_pkg holds:
  - state enum (STAND, RISE, FALL, DEAD)
  - profile band boundaries 80/160/240/320
  - 9-bit saturation limit 511
- Sub-module cube_step_profile: combinational; inputs tg and dir (rise/fall), output step. Shared by RISE and FALL.

Test Plan:
- Reset, no input -> cube_x=160, cube_y=310, state STAND, time_gap=0, all flags 0; cube stays put for 100 cycles.
- Jump pulse from reset -> cube_y decreases 1/cycle for tg 1..79; after 320 cycles the cube enters FALL with time_gap=1.
- Start with cube_y=60: jump -> cube_y reaches 40 at tg=20; hit_ceiling=1 from then until tg=320; cube_y stays 40.
- move_r held with floor 0 only -> at cube_x=250 the support test fails -> FALL; cube_y increases at the 1/8 rate first, and cube lands on floor 1 (x=300? no) -> continues to BOTTOM_Y -> game_over=1, DEAD.
- Jump plus move_r toward floor 1 (y=460) -> lands with cube_y=440, state STAND, time_gap=0.
- With DOUBLE_JUMP_EN: a second jump in FALL -> RISE, time_gap=1; a third jump in FALL is ignored until landing.
